// File: rtl/handshake_pkg.sv
// Shared types and sizing helpers for the four-phase req/ack handshake pair.
package handshake_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } hs_state_t;

  // Phase counter width for a given timeout limit; never narrower than 1 bit.
  function automatic int tmo_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/hs_timer.sv
// Saturating per-phase wait counter; flags the last allowed cycle of a phase.
module hs_timer
  import handshake_pkg::*;
#(
  parameter int LIMIT = 255,
  parameter int WIDTH = tmo_width(LIMIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WIDTH-1:0] LAST = (LIMIT == 0) ? '0 : WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear)
      cnt <= '0;
    else if (enable && (cnt != '1))
      cnt <= cnt + WIDTH'(1);
  end

  // LIMIT of zero disables expiry entirely.
  assign expired = (LIMIT != 0) && (cnt == LAST);

endmodule

// File: rtl/handshake_initiator.sv
// Initiating side of a four-phase req/ack handshake fed by a valid/ready stream,
// with per-phase timeout so a stalled responder cannot hang upstream.
module handshake_initiator
  import handshake_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             req,
  output logic [WIDTH-1:0] data_out,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  hs_state_t        state, state_n;
  logic             req_n, done_n, tmo_n, abort, abort_n;
  logic [WIDTH-1:0] data_n;
  logic             t_clear, t_en, t_expired;

  hs_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (t_clear),
    .enable (t_en),
    .expired(t_expired)
  );

  // A lingering ack from an aborted transfer blocks new accepts.
  assign in_ready = (state == IDLE) && !ack;
  assign busy     = (state != IDLE);

  always_comb begin
    state_n = state;
    req_n   = req;
    data_n  = data_out;
    done_n  = 1'b0;
    tmo_n   = 1'b0;
    abort_n = abort;
    t_clear = 1'b0;
    t_en    = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_n  = in_data;
          req_n   = 1'b1;
          t_clear = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        if (ack) begin
          req_n   = 1'b0;
          t_clear = 1'b1;
          state_n = RELEASE;
        end else if (t_expired) begin
          req_n   = 1'b0;
          tmo_n   = 1'b1;
          abort_n = 1'b1;
          t_clear = 1'b1;
          state_n = RELEASE;
        end else begin
          t_en = 1'b1;
        end
      end
      RELEASE: begin
        if (!ack) begin
          done_n  = !abort;
          abort_n = 1'b0;
          t_clear = 1'b1;
          state_n = IDLE;
        end else if (t_expired) begin
          tmo_n   = 1'b1;
          abort_n = 1'b0;
          t_clear = 1'b1;
          state_n = IDLE;
        end else begin
          t_en = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      req      <= 1'b0;
      data_out <= '0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      abort    <= 1'b0;
    end else begin
      state    <= state_n;
      req      <= req_n;
      data_out <= data_n;
      done     <= done_n;
      timeout  <= tmo_n;
      abort    <= abort_n;
    end
  end

endmodule

// File: tb/tb_handshake_initiator.sv
// Scoreboard bench: a behavioural responder drives ack with chosen latencies,
// the expected outcome of each transfer is queued at accept and checked on pulses.
module tb_handshake_initiator;

  localparam int W   = 8;
  localparam int TMO = 4;

  logic         clk = 1'b0;
  logic         rst, in_valid, ack;
  logic [W-1:0] in_data;
  logic         in_ready, req, busy, done, timeout;
  logic [W-1:0] data_out;

  handshake_initiator #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .req     (req),
    .data_out(data_out),
    .ack     (ack),
    .busy    (busy),
    .done    (done),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           tmo;
    logic [W-1:0] data;
  } exp_t;

  exp_t         q[$];
  exp_t         mon_e;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           acc_cyc = 0;
  logic [W-1:0] cur_word = '0;
  bit           track = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done/timeout pulse must match the next queued outcome.
  always @(negedge clk) begin
    if (!rst) begin
      if (done || timeout) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got done=%0b timeout=%0b, expected none", done, timeout);
        end else begin
          mon_e = q.pop_front();
          chk("pulse_kind", {62'd0, done, timeout}, mon_e.tmo ? 64'd1 : 64'd2);
          chk("pulse_data", data_out, mon_e.data);
        end
      end
      if (busy && track) chk("data_hold", data_out, cur_word);
    end
  end

  task automatic accept(input logic [W-1:0] w, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = w;
      #1;
      if (in_ready) begin
        @(posedge clk);
        ok       = 1'b1;
        cur_word = w;
        track    = 1'b1;
        acc_cyc  = cyc;
        break;
      end
    end
    if (!ok) chk("accept_wait", 64'd0, 64'd1);
  endtask

  // a: negedges after req seen before ack rises (>=TMO: never rises).
  // r: negedges after req falls before ack drops (>=TMO: held for r+1, forcing a timeout).
  task automatic xfer(input logic [W-1:0] w, input int a, input int r, input int gap);
    bit   ok;
    int   req_hi;
    exp_t e;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    accept(w, ok);
    if (!ok) return;
    e.tmo  = !((a < TMO) && (r < TMO));
    e.data = w;
    q.push_back(e);
    req_hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (!req) break;
      req_hi++;
      if (i == a) ack = 1'b1;
    end
    chk("req_high_cycles", req_hi, (a < TMO) ? a + 1 : TMO);
    if (a >= TMO) return;
    if (r < TMO) begin
      repeat (r) @(negedge clk);
      ack = 1'b0;
    end else begin
      for (int j = 0; j <= r; j++) begin
        if (j >= TMO) begin
          #1;
          chk("idle_blocked_by_ack", {62'd0, busy, in_ready}, 64'd0);
        end
        @(negedge clk);
      end
      ack = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  c1, c2;
    bit  ok;
    int  a, r;
    rst = 1'b1; in_valid = 1'b0; ack = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", data_out, 0);
    chk("rst_pulses", {done, timeout}, 0);
    chk("rst_ready", in_ready, 1);
    @(negedge clk) rst = 1'b0;

    xfer(8'hA5, 2, 1, 0);

    xfer(8'h01, 0, 0, 0); c1 = acc_cyc;
    xfer(8'h02, 0, 0, 0); c2 = acc_cyc;
    chk("b2b_spacing_1", c2 - c1, 3);
    xfer(8'h03, 0, 0, 0);
    chk("b2b_spacing_2", acc_cyc - c2, 3);

    xfer(8'h77, TMO, 0, 2);
    xfer(8'h5A, 1, TMO + 2, 1);
    xfer(8'hC3, TMO - 1, TMO - 1, 0);

    accept(8'h3C, ok);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_req", req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_data", data_out, 0);
    chk("midrst_pulses", {done, timeout}, 0);
    @(negedge clk) rst = 1'b0;

    for (int k = 0; k < 40; k++) begin
      a = $urandom_range(0, TMO + 1);
      r = $urandom_range(0, TMO + 3);
      xfer(W'($urandom), a, r, $urandom_range(0, 2));
    end

    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
